regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between two writeback sources: requester 0 (ALU writeback) and requester 1 (load/memory unit). Each requester feeds a one-entry input slot through a valid/ready handshake. A round-robin arbiter drains one slot per cycle into a registered write stage that drives write_reg_en/write_reg/write_data into the register file. A pending-write bitmap is exported for hazard detection by the issue logic.

Parameters:
WORD_LENGTH, 16, data width and number of architectural registers.
ID_LENGTH, 4, register index width; 2**ID_LENGTH == WORD_LENGTH.

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
in_valid0  input  1  requester 0 offers a write
in_reg0  input  ID_LENGTH  requester 0 target register
in_data0  input  WORD_LENGTH  requester 0 write data
in_ready0  output  1  slot 0 can accept this cycle
in_valid1  input  1  requester 1 offers a write
in_reg1  input  ID_LENGTH  requester 1 target register
in_data1  input  WORD_LENGTH  requester 1 write data
in_ready1  output  1  slot 1 can accept this cycle
write_reg_en  output  1  register file write enable (registered)
write_reg  output  ID_LENGTH  register file write index (registered)
write_data  output  WORD_LENGTH  register file write data (registered)
pending  output  WORD_LENGTH  bit r set while a write to register r is in a slot or the write stage
busy  output  1  any slot valid or write_reg_en high

Behaviour:
- Reset (async, immediate): both slots empty, write_reg_en=0, write_reg=0, write_data=0, rr_ptr=0 (requester 0 favoured), pending=0, busy=0. Reset mid-operation discards all buffered writes; nothing reaches the register file.
- Handshake: a transfer happens at a posedge where in_validX && in_readyX. in_readyX = !slotX_valid || grantX (combinational; a drained slot refills in the same cycle). Requesters hold valid/reg/data stable until accepted; no valid-before-ready dependency.
- Arbitration (combinational on slot state only): one slot valid -> grant it. Both valid -> grant slot rr_ptr. rr_ptr toggles only on a contended grant, pointing to the loser; uncontended grants leave it unchanged.
- Write stage: at the posedge after a grant, write_reg/write_data load the granted slot's contents; write_reg_en=1 for exactly that cycle unless the target is register 0, in which case write_reg_en=0 (write silently dropped, slot still drained). No grant -> write_reg_en=0; write_reg/write_data hold.
- Latency: accepted at edge N -> earliest write_reg_en high in cycle after edge N+1 -> register file updated at edge N+2. Losing slot adds 1 cycle per lost round.
- Throughput: one register-file write per cycle sustained; each requester guaranteed at least every other cycle under contention.
- Ordering: per requester, strict FIFO order. Across requesters, no ordering by register index; same-target conflicts are resolved by issue logic using pending.
- pending[r] = (slot0_valid && slot0_reg==r) | (slot1_valid && slot1_reg==r) | (write_reg_en && write_reg==r); pending[0] always 0.

Decomposition:
- Shared package (defines.sv): requester index typedef (REQ_ALU=0, REQ_MEM=1), NUM_REQ=2 localparam, slot struct {valid, reg, data} parameterised by widths via macro.
- Sub-module regfile_wr_slot: one-entry buffer with load/drain, valid flag and async reset; instantiated twice.

Test Plan:
- Reset: assert rst mid-stream with both slots full -> next cycle in_ready0=in_ready1=1, write_reg_en=0, pending=0, no write observed at register file.
- Single requester: req0 writes reg 5 = 16'h00A5 accepted at edge N -> write_reg_en=1, write_reg=5, write_data=16'h00A5 in cycle after N+1; pending[5]=1 for two cycles.
- Contention: both valid every cycle (req0 reg 1..4, req1 reg 9..12) -> write order 1,9,2,10,3,11,4,12; one write per cycle, no bubbles after first.
- Register 0: req1 writes reg 0 = 16'hFFFF -> in_ready1 handshake completes, write_reg_en stays 0, pending[0]=0.
- Back-pressure: req0 valid continuously while req1 contends -> in_ready0 low on cycles slot 0 loses, no request lost or duplicated; scoreboard matches per-requester order.
- Uncontended pointer: req1 alone for 3 writes, then both contend -> req0 wins first contended grant (rr_ptr unchanged at 0).

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: requester ids and the
// input-slot record layout.
`ifndef REGFILE_WRITE_ARBITER_PKG_SV
`define REGFILE_WRITE_ARBITER_PKG_SV

// Slot record {valid, target register, data}; widths follow the instantiating module.
`define RWA_SLOT_T(IW, DW) struct packed { \
  logic            valid; \
  logic [(IW)-1:0] wreg; \
  logic [(DW)-1:0] data; \
}

package regfile_write_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

`endif

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file.
interface regfile_write_arbiter_if #(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned ID_LENGTH   = 4
);
    logic                   in_valid0;
    logic [ID_LENGTH-1:0]   in_reg0;
    logic [WORD_LENGTH-1:0] in_data0;
    logic                   in_ready0;
    logic                   in_valid1;
    logic [ID_LENGTH-1:0]   in_reg1;
    logic [WORD_LENGTH-1:0] in_data1;
    logic                   in_ready1;
    logic                   write_reg_en;
    logic [ID_LENGTH-1:0]   write_reg;
    logic [WORD_LENGTH-1:0] write_data;
    logic [WORD_LENGTH-1:0] pending;
    logic                   busy;

    modport master (
        output in_valid0, in_reg0, in_data0, in_valid1, in_reg1, in_data1,
        input  in_ready0, in_ready1, write_reg_en, write_reg, write_data, pending, busy
    );

    modport slave (
        input  in_valid0, in_reg0, in_data0, in_valid1, in_reg1, in_data1,
        output in_ready0, in_ready1, write_reg_en, write_reg, write_data, pending, busy
    );
endinterface

// File: rtl/regfile_wr_slot.sv
// One-entry writeback buffer; a load in the same cycle as a drain refills it.
module regfile_wr_slot
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned ID_LENGTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   drain,
    input  logic [ID_LENGTH-1:0]   load_reg,
    input  logic [WORD_LENGTH-1:0] load_data,
    output logic                   slot_valid,
    output logic [ID_LENGTH-1:0]   slot_reg,
    output logic [WORD_LENGTH-1:0] slot_data
);
    typedef `RWA_SLOT_T(ID_LENGTH, WORD_LENGTH) slot_t;

    slot_t slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else if (load) begin
            slot_q <= '{valid: 1'b1, wreg: load_reg, data: load_data};
        end else if (drain) begin
            slot_q.valid <= 1'b0;
        end
    end

    assign slot_valid = slot_q.valid;
    assign slot_reg   = slot_q.wreg;
    assign slot_data  = slot_q.data;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and memory writeback slots, with a registered write stage and pending bitmap.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned ID_LENGTH   = 4
) (
    input logic              clk,
    input logic              rst,
    regfile_write_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0]     in_valid;
    logic [NUM_REQ-1:0]     in_ready;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     load;
    logic [NUM_REQ-1:0]     s_valid;
    logic [ID_LENGTH-1:0]   in_reg  [NUM_REQ];
    logic [WORD_LENGTH-1:0] in_data [NUM_REQ];
    logic [ID_LENGTH-1:0]   s_reg   [NUM_REQ];
    logic [WORD_LENGTH-1:0] s_data  [NUM_REQ];

    req_e                   rr_ptr;
    logic                   gidx;
    logic                   wr_en_q;
    logic [ID_LENGTH-1:0]   wr_reg_q;
    logic [WORD_LENGTH-1:0] wr_data_q;
    logic [WORD_LENGTH-1:0] pending;

    assign in_valid   = {bus.in_valid1, bus.in_valid0};
    assign in_reg[0]  = bus.in_reg0;
    assign in_reg[1]  = bus.in_reg1;
    assign in_data[0] = bus.in_data0;
    assign in_data[1] = bus.in_data1;

    // Grant depends on slot state only, so ready never waits on valid.
    assign grant[0] = s_valid[0] && (!s_valid[1] || rr_ptr == REQ_ALU);
    assign grant[1] = s_valid[1] && (!s_valid[0] || rr_ptr == REQ_MEM);
    assign gidx     = grant[1];
    assign in_ready = ~s_valid | grant;
    assign load     = in_valid & in_ready;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        regfile_wr_slot #(
            .WORD_LENGTH(WORD_LENGTH),
            .ID_LENGTH  (ID_LENGTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .drain     (grant[i]),
            .load_reg  (in_reg[i]),
            .load_data (in_data[i]),
            .slot_valid(s_valid[i]),
            .slot_reg  (s_reg[i]),
            .slot_data (s_data[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= REQ_ALU;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            // Pointer moves to the loser only when both slots compete.
            if (&s_valid) begin
                rr_ptr <= (rr_ptr == REQ_ALU) ? REQ_MEM : REQ_ALU;
            end
            if (|grant) begin
                wr_reg_q  <= s_reg[gidx];
                wr_data_q <= s_data[gidx];
                wr_en_q   <= (s_reg[gidx] != '0);
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < WORD_LENGTH; r++) begin
            pending[r] = (s_valid[0] && s_reg[0] == ID_LENGTH'(r))
                       | (s_valid[1] && s_reg[1] == ID_LENGTH'(r))
                       | (wr_en_q && wr_reg_q == ID_LENGTH'(r));
        end
    end

    assign bus.in_ready0    = in_ready[0];
    assign bus.in_ready1    = in_ready[1];
    assign bus.write_reg_en = wr_en_q;
    assign bus.write_reg    = wr_reg_q;
    assign bus.write_data   = wr_data_q;
    assign bus.pending      = pending;
    assign bus.busy         = (|s_valid) | wr_en_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of the write arbiter against a cycle model
// built from the arbitration and write-stage rules.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_write_arbiter_if #(.WORD_LENGTH(16), .ID_LENGTH(4)) bus ();

    regfile_write_arbiter #(.WORD_LENGTH(16), .ID_LENGTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Requester-side stimulus.
    bit          iv [2];
    logic [3:0]  ir [2];
    logic [15:0] id [2];
    bit          acc [2];

    // Reference model state.
    bit          mv [2];
    logic [3:0]  mr [2];
    logic [15:0] md [2];
    int          mptr;
    bit          men;
    logic [3:0]  mwr;
    logic [15:0] mwd;

    logic [3:0]  wq [$];
    int          writes_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; mr[i] = '0; md[i] = '0; iv[i] = 0; acc[i] = 0;
        end
        mptr = 0; men = 0; mwr = '0; mwd = '0;
    endtask

    task automatic apply();
        bus.in_valid0 = iv[0]; bus.in_reg0 = ir[0]; bus.in_data0 = id[0];
        bus.in_valid1 = iv[1]; bus.in_reg1 = ir[1]; bus.in_data1 = id[1];
    endtask

    // One clock: check outputs against the model, then advance both across the edge.
    task automatic cycle();
        bit g [2];
        bit rdy [2];
        int gi;
        logic [15:0] exp_pend;
        apply();
        #1;
        g[0] = mv[0] && (!mv[1] || mptr == 0);
        g[1] = mv[1] && (!mv[0] || mptr == 1);
        for (int i = 0; i < 2; i++) rdy[i] = !mv[i] || g[i];
        exp_pend = '0;
        for (int r = 1; r < 16; r++) begin
            if ((mv[0] && mr[0] == r) || (mv[1] && mr[1] == r) || (men && mwr == r))
                exp_pend[r] = 1'b1;
        end
        chk("in_ready0", {31'b0, bus.in_ready0}, {31'b0, rdy[0]});
        chk("in_ready1", {31'b0, bus.in_ready1}, {31'b0, rdy[1]});
        chk("write_reg_en", {31'b0, bus.write_reg_en}, {31'b0, men});
        chk("write_reg", {28'b0, bus.write_reg}, {28'b0, mwr});
        chk("write_data", {16'b0, bus.write_data}, {16'b0, mwd});
        chk("pending", {16'b0, bus.pending}, {16'b0, exp_pend});
        chk("busy", {31'b0, bus.busy}, {31'b0, (mv[0] || mv[1] || men)});
        if (bus.write_reg_en) begin
            wq.push_back(bus.write_reg);
            writes_seen++;
        end
        @(posedge clk);
        #1;
        if (g[0] || g[1]) begin
            gi  = g[0] ? 0 : 1;
            men = (mr[gi] != 0);
            mwr = mr[gi];
            mwd = md[gi];
        end else begin
            men = 0;
        end
        if (mv[0] && mv[1]) mptr = 1 - mptr;
        for (int i = 0; i < 2; i++) begin
            acc[i] = iv[i] && rdy[i];
            if (acc[i]) begin
                mv[i] = 1; mr[i] = ir[i]; md[i] = id[i];
            end else if (g[i]) begin
                mv[i] = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        iv[0] = 0; iv[1] = 0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int idx0, idx1, guard, acc_nz;
        logic [3:0] exp_order [8];
        model_reset();
        for (int i = 0; i < 2; i++) begin ir[i] = '0; id[i] = '0; end
        writes_seen = 0;
        apply();
        #12;
        chk("reset_ready0", {31'b0, bus.in_ready0}, 32'd1);
        chk("reset_en", {31'b0, bus.write_reg_en}, 32'd0);
        chk("reset_pending", {16'b0, bus.pending}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Uncontended grants from req1 leave the pointer favouring req0.
        for (int k = 0; k < 3; k++) begin
            iv[1] = 1; ir[1] = 4'(6 + k); id[1] = 16'(16'h0100 + k);
            cycle();
            chk("ptr_req1_acc", {31'b0, acc[1]}, 32'd1);
        end
        idle(3);
        wq.delete();
        iv[0] = 1; ir[0] = 4'd3;  id[0] = 16'h0303;
        iv[1] = 1; ir[1] = 4'd13; id[1] = 16'h0D0D;
        cycle();
        idle(4);
        chk("ptr_order_len", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("ptr_first", {28'b0, wq[0]}, 32'd3);
            chk("ptr_second", {28'b0, wq[1]}, 32'd13);
        end

        // Single write to reg 5: visible two cycles after acceptance.
        iv[0] = 1; ir[0] = 4'd5; id[0] = 16'h00A5;
        cycle();
        chk("single_acc", {31'b0, acc[0]}, 32'd1);
        iv[0] = 0;
        chk("single_pend1", {16'b0, bus.pending}, 32'h0020);
        chk("single_en1", {31'b0, bus.write_reg_en}, 32'd0);
        cycle();
        chk("single_en2", {31'b0, bus.write_reg_en}, 32'd1);
        chk("single_reg", {28'b0, bus.write_reg}, 32'd5);
        chk("single_data", {16'b0, bus.write_data}, 32'h00A5);
        chk("single_pend2", {16'b0, bus.pending}, 32'h0020);
        cycle();
        chk("single_en3", {31'b0, bus.write_reg_en}, 32'd0);
        idle(2);

        // Register 0 is accepted and drained but never written.
        iv[1] = 1; ir[1] = 4'd0; id[1] = 16'hFFFF;
        cycle();
        chk("r0_acc", {31'b0, acc[1]}, 32'd1);
        iv[1] = 0;
        chk("r0_pend", {16'b0, bus.pending}, 32'd0);
        cycle();
        chk("r0_en", {31'b0, bus.write_reg_en}, 32'd0);
        idle(2);

        // Reset with both slots full discards everything.
        writes_seen = 0;
        iv[0] = 1; ir[0] = 4'd2; id[0] = 16'h2222;
        iv[1] = 1; ir[1] = 4'd3; id[1] = 16'h3333;
        cycle();
        rst = 1'b1;
        #1;
        chk("rst_ready0", {31'b0, bus.in_ready0}, 32'd1);
        chk("rst_ready1", {31'b0, bus.in_ready1}, 32'd1);
        chk("rst_en", {31'b0, bus.write_reg_en}, 32'd0);
        chk("rst_pending", {16'b0, bus.pending}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        model_reset();
        apply();
        @(posedge clk); #1;
        chk("rst_en_hold", {31'b0, bus.write_reg_en}, 32'd0);
        rst = 1'b0;
        idle(3);
        chk("rst_no_write", writes_seen, 32'd0);

        // Full contention: strict alternation, one write per cycle.
        wq.delete();
        idx0 = 0; idx1 = 0; guard = 0;
        while ((idx0 < 4 || idx1 < 4) && guard < 40) begin
            iv[0] = idx0 < 4; ir[0] = 4'(1 + idx0); id[0] = 16'(16'h1000 + idx0);
            iv[1] = idx1 < 4; ir[1] = 4'(9 + idx1); id[1] = 16'(16'h9000 + idx1);
            cycle();
            if (acc[0]) idx0++;
            if (acc[1]) idx1++;
            guard++;
        end
        idle(4);
        exp_order = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4, 4'd12};
        chk("cont_len", wq.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < wq.size()) chk($sformatf("cont_order%0d", k), {28'b0, wq[k]},
                                   {28'b0, exp_order[k]});
        end

        // Random traffic with back-pressure; requesters hold until accepted.
        writes_seen = 0; acc_nz = 0;
        iv[0] = 0; iv[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!iv[i] && $urandom_range(0, 3) != 0) begin
                    iv[i] = 1;
                    ir[i] = 4'($urandom_range(0, 15));
                    id[i] = 16'($urandom);
                end
            end
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    if (ir[i] != 0) acc_nz++;
                    iv[i] = 0;
                end
            end
        end
        idle(4);
        chk("rand_write_count", writes_seen, acc_nz);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
